// File: rtl/mean_controller.sv
// mean_controller: control FSM sequencing the mean datapath.
// Running mean update: mean_new = (mean_old >> 1) + (x >> 1), published
// through REG2 with a one-cycle mean_valid pulse.
// Optional build macro MEAN_CTRL_COUNT_EN adds a saturating sample_count output.
module mean_controller #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clear,
  output logic [5:0]       select,
  output logic [2:0]       load,
  output logic             mean_valid
`ifdef MEAN_CTRL_COUNT_EN
  ,
  output logic [CNT_W-1:0] sample_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    WB   = 2'd2,
    PUB  = 2'd3
  } state_t;

  state_t state;
  logic   first_pending;
  logic   accept;

  // Datapath control decode: a function of state, plus the handshake in IDLE.
  always_comb begin
    in_ready = 1'b0;
    accept   = 1'b0;
    select   = '0;
    load     = '0;
    case (state)
      IDLE: begin
        in_ready = ~clear;
        accept   = in_valid & ~clear;
        if (accept) begin
          if (first_pending) begin
            load = 3'b100;
          end else begin
            select = 6'b000111;
          end
        end
      end
      ADD: begin
        load = 3'b010;
      end
      WB: begin
        select = 6'b001000;
        load   = 3'b100;
      end
      PUB: begin
        select = 6'b100000;
        load   = 3'b001;
      end
      default: begin
        select = '0;
        load   = '0;
      end
    endcase
  end

  // State sequencing, first-sample tracking and the registered publish pulse.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= IDLE;
      first_pending <= 1'b1;
      mean_valid    <= 1'b0;
    end else begin
      mean_valid <= (state == PUB);
      case (state)
        IDLE: begin
          if (clear) begin
            first_pending <= 1'b1;
          end else if (accept) begin
            if (first_pending) begin
              first_pending <= 1'b0;
              state         <= PUB;
            end else begin
              state <= ADD;
            end
          end
        end
        ADD:     state <= WB;
        WB:      state <= PUB;
        PUB:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEAN_CTRL_COUNT_EN
  // Accepted-sample counter, saturating at all-ones, zeroed by reset or idle clear.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sample_count <= '0;
    end else if ((state == IDLE) && clear) begin
      sample_count <= '0;
    end else if (accept && (sample_count != '1)) begin
      sample_count <= sample_count + 1'b1;
    end
  end
`else
  // Counter width has no role without the counter; keep it referenced.
  if (CNT_W > 0) begin : g_no_count
  end
`endif

endmodule

// File: tb/tb_mean_controller.sv
// Directed bench for mean_controller with a behavioural datapath model
// driven by select/load, so published means can be checked end to end.
module tb_mean_controller;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic        clear;
  logic [5:0]  select;
  logic [2:0]  load;
  logic        mean_valid;
  logic [15:0] data_in;
`ifdef MEAN_CTRL_COUNT_EN
  logic [15:0] sample_count;
`endif

  always #5 clock = ~clock;

  mean_controller #(.CNT_W(16)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .clear      (clear),
    .select     (select),
    .load       (load),
    .mean_valid (mean_valid)
`ifdef MEAN_CTRL_COUNT_EN
    ,
    .sample_count (sample_count)
`endif
  );

  // Datapath model: shifters capture x>>1 and mean>>1, REG3 holds the sum,
  // REG1 is the accumulator, REG2 drives data_out.
  logic [15:0] sh_x, sh_m, reg1, reg2, reg3;
  always @(posedge clock) begin
    if (select[0]) sh_x <= data_in >> 1;
    if (select[1]) sh_m <= reg1 >> 1;
    if (load[1])   reg3 <= sh_x + sh_m;
    if (load[2])   reg1 <= select[3] ? reg3 : data_in;
    if (load[0])   reg2 <= reg1;
  end

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_ctl(input string tag, input logic ir, input logic [5:0] sel,
                            input logic [2:0] ld, input logic mv);
    #1;
    check({tag, " in_ready"},   {31'd0, in_ready},   {31'd0, ir});
    check({tag, " select"},     {26'd0, select},     {26'd0, sel});
    check({tag, " load"},       {29'd0, load},       {29'd0, ld});
    check({tag, " mean_valid"}, {31'd0, mean_valid}, {31'd0, mv});
  endtask

  // Samples 100, 50, 20 with in_valid held: accepts at 0, 2, 6.
  logic       e_ir  [0:10] = '{1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
  logic [5:0] e_sel [0:10] = '{0, 32, 7, 0, 8, 32, 7, 0, 8, 32, 0};
  logic [2:0] e_ld  [0:10] = '{4, 1, 0, 2, 4, 1, 0, 2, 4, 1, 0};
  logic       e_mv  [0:10] = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
  logic [15:0] e_do [0:10] = '{0, 0, 100, 0, 0, 0, 75, 0, 0, 0, 47};

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    clear    = 1'b0;
    data_in  = '0;
    tick();
    tick();
    reset_n = 1'b1;
    expect_ctl("reset", 1'b1, 6'd0, 3'd0, 1'b0);

    // Single first sample.
    data_in = 16'd100; in_valid = 1'b1;
    expect_ctl("s1 accept", 1'b1, 6'b000000, 3'b100, 1'b0);
    tick();
    in_valid = 1'b0;
    expect_ctl("s1 pub", 1'b0, 6'b100000, 3'b001, 1'b0);
    tick();
    expect_ctl("s1 done", 1'b1, 6'd0, 3'd0, 1'b1);
    check("s1 data_out", {16'd0, reg2}, 32'd100);

    // Fresh start, three samples back to back.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      in_valid = (c < 10);
      data_in  = (c < 2) ? 16'd100 : (c < 6) ? 16'd50 : 16'd20;
      expect_ctl($sformatf("s2 c%0d", c), e_ir[c], e_sel[c], e_ld[c], e_mv[c]);
      if (e_mv[c]) check($sformatf("s2 c%0d data_out", c), {16'd0, reg2}, {16'd0, e_do[c]});
      if (c < 10) tick();
    end

    // Clear for one idle cycle, then sample 8 takes the first-sample path.
    tick();
    clear = 1'b1;
    expect_ctl("s3 clear", 1'b0, 6'd0, 3'd0, 1'b0);
    tick();
    clear = 1'b0; in_valid = 1'b1; data_in = 16'd8;
    expect_ctl("s3 accept", 1'b1, 6'd0, 3'b100, 1'b0);
    tick();
    in_valid = 1'b0;
    expect_ctl("s3 pub", 1'b0, 6'b100000, 3'b001, 1'b0);
    tick();
    expect_ctl("s3 done", 1'b1, 6'd0, 3'd0, 1'b1);
    check("s3 data_out", {16'd0, reg2}, 32'd8);
`ifdef MEAN_CTRL_COUNT_EN
    check("s3 count", {16'd0, sample_count}, 32'd1);
`endif

    // Clear and valid together: clear wins; next cycle accepts as first.
    tick();
    clear = 1'b1; in_valid = 1'b1; data_in = 16'd200;
    expect_ctl("s4 both", 1'b0, 6'd0, 3'd0, 1'b0);
    tick();
    clear = 1'b0;
    expect_ctl("s4 accept", 1'b1, 6'd0, 3'b100, 1'b0);
    tick();
    in_valid = 1'b0;
    expect_ctl("s4 pub", 1'b0, 6'b100000, 3'b001, 1'b0);
    tick();
    expect_ctl("s4 done", 1'b1, 6'd0, 3'd0, 1'b1);
    check("s4 data_out", {16'd0, reg2}, 32'd200);

    // Reset during WB aborts the update; the next sample is a first sample.
    tick();
    in_valid = 1'b1; data_in = 16'd60;
    expect_ctl("s5 accept", 1'b1, 6'b000111, 3'd0, 1'b0);
    tick();
    in_valid = 1'b0;
    expect_ctl("s5 add", 1'b0, 6'd0, 3'b010, 1'b0);
    tick();
    expect_ctl("s5 wb", 1'b0, 6'b001000, 3'b100, 1'b0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    expect_ctl("s5 idle", 1'b1, 6'd0, 3'd0, 1'b0);
    tick();
    expect_ctl("s5 nopulse", 1'b1, 6'd0, 3'd0, 1'b0);
    in_valid = 1'b1; data_in = 16'd30;
    expect_ctl("s5 first", 1'b1, 6'd0, 3'b100, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    expect_ctl("s5 done", 1'b1, 6'd0, 3'd0, 1'b1);
    check("s5 data_out", {16'd0, reg2}, 32'd30);

    // Full-scale samples; clear pulsed while busy is ignored.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    in_valid = 1'b1; data_in = 16'hFFFF;
    tick();
    in_valid = 1'b0;
    tick();
    check("s6 first", {16'd0, reg2}, 32'd65535);
    in_valid = 1'b1;
    expect_ctl("s6 accept", 1'b1, 6'b000111, 3'd0, 1'b1);
    tick();
    in_valid = 1'b0; clear = 1'b1;
    expect_ctl("s6 add", 1'b0, 6'd0, 3'b010, 1'b0);
    tick();
    clear = 1'b0;
    expect_ctl("s6 wb", 1'b0, 6'b001000, 3'b100, 1'b0);
    tick();
    tick();
    expect_ctl("s6 done", 1'b1, 6'd0, 3'd0, 1'b1);
    check("s6 data_out", {16'd0, reg2}, 32'd65534);
`ifdef MEAN_CTRL_COUNT_EN
    check("s6 count", {16'd0, sample_count}, 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
